// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - write-back queue feeding the single register-file write port
//
// Collects ALU results and late load results into a small circular buffer
// and drains one register write per cycle. A load presented in the same cycle
// as an ALU result is stored first because it belongs to the older instruction.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   alu_valid_i/rd/data   ALU result; a destination of register 0 is ignored
//   mem_valid_i/rd/data   load result; a destination of register 0 is ignored
//   stall_o               fewer than two free slots; producers must hold off
//   RegWrite_o/rd_o/data_o  registered register-file write (one entry per cycle)
//   count_o               occupied entries
//   overflow_o            sticky: a result was dropped because the queue was full
module reg_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              mem_req;
  logic              alu_req;
  logic              do_deq;
  logic              mem_acc;
  logic              alu_acc;
  logic              drop;
  logic [CNT_W-1:0]  free_slots;
  logic [CNT_W-1:0]  n_enq;
  logic [PTR_W-1:0]  alu_slot;

  always_comb begin
    mem_req    = mem_valid_i && (mem_rd_i != '0);
    alu_req    = alu_valid_i && (alu_rd_i != '0);
    do_deq     = (count != '0);
    // The head leaving this edge frees its slot for an incoming result.
    free_slots = CNT_W'(DEPTH) - count + CNT_W'(do_deq);
    mem_acc    = mem_req && (free_slots >= CNT_W'(1));
    alu_acc    = alu_req && (free_slots >= (mem_acc ? CNT_W'(2) : CNT_W'(1)));
    drop       = (mem_req && !mem_acc) || (alu_req && !alu_acc);
    alu_slot   = mem_acc ? wr_ptr + PTR_W'(1) : wr_ptr;
    n_enq      = CNT_W'(mem_acc) + CNT_W'(alu_acc);
  end

  // Payload storage needs no reset; only entries covered by count are ever read.
  always_ff @(posedge clk_i) begin
    if (mem_acc) begin
      rd_mem[wr_ptr]   <= mem_rd_i;
      data_mem[wr_ptr] <= mem_data_i;
    end
    if (alu_acc) begin
      rd_mem[alu_slot]   <= alu_rd_i;
      data_mem[alu_slot] <= alu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      RegWrite_o <= 1'b0;
      rd_o       <= '0;
      data_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_deq) begin
        RegWrite_o <= 1'b1;
        rd_o       <= rd_mem[rd_ptr];
        data_o     <= data_mem[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end else begin
        RegWrite_o <= 1'b0;
      end
      wr_ptr <= wr_ptr + PTR_W'(n_enq);
      count  <= count + n_enq - CNT_W'(do_deq);
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  assign stall_o = (count > CNT_W'(DEPTH - 2));
  assign count_o = count;

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - scoreboard bench for reg_wb_queue
module tb_reg_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              alu_valid_i = 1'b0;
  logic [ADDR_W-1:0] alu_rd_i = '0;
  logic [DATA_W-1:0] alu_data_i = '0;
  logic              mem_valid_i = 1'b0;
  logic [ADDR_W-1:0] mem_rd_i = '0;
  logic [DATA_W-1:0] mem_data_i = '0;
  logic              stall_o;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] rd_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;

  reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .mem_valid_i (mem_valid_i),
    .mem_rd_i    (mem_rd_i),
    .mem_data_i  (mem_data_i),
    .stall_o     (stall_o),
    .RegWrite_o  (RegWrite_o),
    .rd_o        (rd_o),
    .data_o      (data_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t model_q[$];
  wr_t exp_q[$];
  bit  model_we  = 1'b0;
  bit  model_ovf = 1'b0;
  bit  in_reset  = 1'b1;
  int  vectors   = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model applies the queue rules at the edge.
  task automatic step(input bit mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                      input bit av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad);
    int free_n;
    @(negedge clk_i);
    mem_valid_i = mv;  mem_rd_i = mrd;  mem_data_i = md;
    alu_valid_i = av;  alu_rd_i = ard;  alu_data_i = ad;
    @(posedge clk_i);
    model_we = (model_q.size() > 0);
    if (model_we) exp_q.push_back(model_q.pop_front());
    free_n = DEPTH - model_q.size();
    if (mv && mrd != 0) begin
      if (free_n > 0) begin model_q.push_back(wr_t'{mrd, md}); free_n--; end
      else model_ovf = 1'b1;
    end
    if (av && ard != 0) begin
      if (free_n > 0) begin model_q.push_back(wr_t'{ard, ad}); free_n--; end
      else model_ovf = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    in_reset = 1'b1;
    #1;
    check("rst_regwrite", RegWrite_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_data", data_o, 0);
    check("rst_count", count_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_stall", stall_o, 0);
    model_q.delete();
    exp_q.delete();
    model_we = 1'b0;
    model_ovf = 1'b0;
    mem_valid_i = 1'b0;
    alu_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compares every cycle's write against the scoreboard queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_i);
      if (!in_reset) begin
        check("regwrite", RegWrite_o, model_we);
        if (RegWrite_o) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rd_o, data_o);
          end else begin
            e = exp_q.pop_front();
            check("rd_o", rd_o, e.rd);
            check("data_o", data_o, e.data);
          end
        end
        check("count_o", count_o, model_q.size());
        check("stall_o", stall_o, model_q.size() > DEPTH - 2);
        check("overflow_o", overflow_o, model_ovf);
      end
    end
  end

  task automatic random_phase(input int n, input bit obey_stall);
    bit mv, av;
    for (int i = 0; i < n; i++) begin
      mv = ($urandom_range(0, 2) == 0);
      av = ($urandom_range(0, 1) == 0);
      if (obey_stall && model_q.size() > DEPTH - 2) begin
        mv = 1'b0;
        av = 1'b0;
      end
      step(mv, ADDR_W'($urandom_range(0, 31)), $urandom,
           av, ADDR_W'($urandom_range(0, 31)), $urandom);
    end
  endtask

  initial begin
    do_reset();
    // single ALU result
    step(0, '0, '0, 1, 5'd8, 32'h0000_1234);
    idle(3);
    // ordering: load first, then ALU
    step(1, 5'd9, 32'hAAAA_AAAA, 1, 5'd10, 32'h5555_5555);
    idle(4);
    // register 0 is never written
    step(0, '0, '0, 1, 5'd0, 32'hDEAD_BEEF);
    step(1, 5'd0, 32'h1111_1111, 0, '0, '0);
    idle(2);
    // fill to stall, then drain
    step(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    step(1, 5'd3, 32'h3, 1, 5'd4, 32'h4);
    idle(5);
    random_phase(200, 1'b1);
    idle(5);
    // drive to full, then a pair that cannot fit: load kept, ALU dropped
    step(1, 5'd11, 32'hB, 1, 5'd12, 32'hC);
    step(1, 5'd13, 32'hD, 1, 5'd14, 32'hE);
    step(1, 5'd15, 32'hF, 1, 5'd16, 32'h10);
    step(1, 5'd17, 32'h11, 1, 5'd18, 32'h12);
    idle(6);
    // ten single writes wrap the pointers
    for (int i = 0; i < 10; i++) step(0, '0, '0, 1, ADDR_W'(i + 1), 32'h100 + i);
    idle(3);
    random_phase(300, 1'b0);
    // reset in the middle of a drain
    step(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
    step(1, 5'd22, 32'h22, 1, 5'd23, 32'h23);
    idle(1);
    do_reset();
    idle(3);
    random_phase(100, 1'b1);
    idle(6);
    check("drain_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
